serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Multi-cycle ripple-borrow subtractor computing `in_sub_a - in_sub_b`, DIGIT_WIDTH bits per clock, least-significant digit first. It is the inverse companion of the registered ripple-carry adder in the sequential arithmetic library, and trades latency for a narrow borrow chain. It uses a start/busy/done handshake and a registered result and borrow that hold until the next operation.

## Interface
- DATA_WIDTH, 32, operand/result width; must be an integer multiple of DIGIT_WIDTH.
- DIGIT_WIDTH, 8, bits processed per cycle; ≥1.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  global clock-enable; low freezes every register.
- start  input  1  request; sampled only when busy=0 and enable=1.
- in_sub_a  input  DATA_WIDTH  minuend, captured on the accepted start.
- in_sub_b  input  DATA_WIDTH  subtrahend, captured on the accepted start.
- out_sub_result  output  DATA_WIDTH  difference mod 2^DATA_WIDTH.
- out_borrow  output  1  1 when in_sub_a < in_sub_b (unsigned).
- busy  output  1  operation in progress.
- done  output  1  one-enabled-cycle pulse; result valid from this cycle.
- out_overflow  output  1  signed overflow (present only with macro; see Configuration).

## Operation
- NDIG = DATA_WIDTH/DIGIT_WIDTH; digit counter width max(1, clog2(NDIG)).
- States: IDLE, RUN.
- IDLE: on start, latch operands, clear borrow and counter, go RUN, busy=1.
- RUN: per cycle, for digit index cnt: {b_out, d} = a[cnt] - b[cnt] - borrow; d written to result digit cnt; borrow <= b_out; cnt++. On cnt==NDIG-1, go IDLE, set done=1, busy=0, out_borrow = final borrow.
- out_sub_result is written only by RUN; it is partially updated during RUN and defined only when done=1 or later, until the next accepted start.
- start while busy=1: ignored, with no queueing.
- start in the cycle done=1 (state IDLE): accepted, giving back-to-back operation.
- enable=0: state, counter, operands, result, borrow, busy and done all hold. A pending done pulse stretches until the next enabled cycle, then clears.
- rst (any time, including mid-RUN): state IDLE; out_sub_result, out_borrow, busy, done and out_overflow are 0; operand registers are 0.

## Timing
- Accepted start at edge k gives busy=1 from k+1 through k+NDIG.
- done=1 and result/borrow valid in the cycle after edge k+NDIG. Latency is NDIG cycles with enable held high; for 32/8 it is 4 cycles.
- NDIG=1: a single RUN cycle, with done one cycle after start.
- done is a registered pulse, high for exactly one enabled cycle per operation.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- SERIAL_SUB_OVERFLOW_EN defined: the out_overflow port exists. It is updated with done and equals (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]). It resets to 0 and holds like out_sub_result.
- Not defined: the port and its logic are absent, and all other behaviour is identical.

## Structure
- The shared arithmetic package holds the state enum (IDLE, RUN) and the NDIG/counter-width helper function.
- Sub-module: full_subtractor, a 1-bit (a, b, bin -> d, bout) cell. Instantiate a ripple chain of DIGIT_WIDTH cells inside serial_subtractor for the digit datapath.

## Test plan
- 32/8, a=100, b=58, start one cycle: done 4 cycles later, result=42, borrow=0, busy high for exactly 4 cycles.
- a=5, b=7: result=0xFFFFFFFE, borrow=1. With the macro: a=0x80000000, b=1 gives 0x7FFFFFFF and overflow=1; a=1, b=2 gives overflow=0.
- Pulse start again on cycle 2 of RUN with different operands: ignored, and the first result is unchanged.
- Drop enable for 3 cycles mid-RUN: done arrives 3 cycles later, with the correct result. Drop enable during done: done stays high until enable returns.
- Assert rst mid-RUN: all outputs 0 immediately. Then a=0xFFFFFFFF, b=0xFFFFFFFF gives result=0 and borrow=0.
- Start asserted on the done cycle: second operation accepted with no gap. Also run DIGIT_WIDTH=32 (NDIG=1): done 1 cycle after start.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared FSM state type and digit-count helpers for the serial subtractor
package serial_subtractor_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    function automatic int calc_ndig(input int data_w, input int digit_w);
        return data_w / digit_w;
    endfunction

    function automatic int calc_cnt_w(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor: 1-bit borrow-ripple cell computing a - b - bin
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle a - b, DIGIT_WIDTH bits per cycle LSD first; SERIAL_SUB_OVERFLOW_EN adds out_overflow
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DIGIT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] in_sub_a,
    input  logic [DATA_WIDTH-1:0] in_sub_b,
    output logic [DATA_WIDTH-1:0] out_sub_result,
    output logic                  out_borrow,
    output logic                  busy,
    output logic                  done
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic                  out_overflow
`endif
);

    localparam int NDIG = calc_ndig(DATA_WIDTH, DIGIT_WIDTH);
    localparam int CW   = calc_cnt_w(NDIG);

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [DATA_WIDTH-1:0]  a_r;
    logic [DATA_WIDTH-1:0]  b_r;
    logic                   borrow;
    logic [DIGIT_WIDTH-1:0] a_dig;
    logic [DIGIT_WIDTH-1:0] b_dig;
    logic [DIGIT_WIDTH-1:0] d_dig;
    logic [DIGIT_WIDTH:0]   bc;
    logic                   last;

    assign last  = cnt == CW'(NDIG - 1);
    assign bc[0] = borrow;

    // select the operand digits addressed by the digit counter
    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (cnt == CW'(i)) begin
                a_dig = a_r[i*DIGIT_WIDTH +: DIGIT_WIDTH];
                b_dig = b_r[i*DIGIT_WIDTH +: DIGIT_WIDTH];
            end
        end
    end

    for (genvar g = 0; g < DIGIT_WIDTH; g++) begin : g_cell
        full_subtractor u_fs (
            .a   (a_dig[g]),
            .b   (b_dig[g]),
            .bin (bc[g]),
            .d   (d_dig[g]),
            .bout(bc[g+1])
        );
    end

    // control FSM plus registered operands, result digits, borrow and handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            a_r            <= '0;
            b_r            <= '0;
            borrow         <= 1'b0;
            out_sub_result <= '0;
            out_borrow     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            out_overflow   <= 1'b0;
`endif
        end else if (enable) begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r    <= in_sub_a;
                        b_r    <= in_sub_b;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NDIG; i++)
                        if (cnt == CW'(i)) out_sub_result[i*DIGIT_WIDTH +: DIGIT_WIDTH] <= d_dig;
                    borrow <= bc[DIGIT_WIDTH];
                    cnt    <= last ? '0 : cnt + 1'b1;
                    if (last) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        out_borrow <= bc[DIGIT_WIDTH];
`ifdef SERIAL_SUB_OVERFLOW_EN
                        out_overflow <= (a_r[DATA_WIDTH-1] != b_r[DATA_WIDTH-1]) &&
                                        (d_dig[DIGIT_WIDTH-1] != a_r[DATA_WIDTH-1]);
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized scoreboard bench for serial_subtractor (32/8 and 32/32 builds)
module tb_serial_subtractor;

    typedef struct packed {
        logic        ovf;
        logic        brw;
        logic [31:0] res;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        start1 = 1'b0, start2 = 1'b0;
    logic [31:0] a1 = '0, b1 = '0, a2 = '0, b2 = '0;
    logic [31:0] r1, r2;
    logic        bo1, bo2, busy1, busy2, done1, done2;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic        ovf1, ovf2;
`endif

    int   vec = 0;
    int   mis = 0;
    int   cyc = 0;
    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;
    bit   seen1 = 1'b0, seen2 = 1'b0;

    serial_subtractor #(.DATA_WIDTH(32), .DIGIT_WIDTH(8)) u1 (
        .clk(clk), .rst(rst), .enable(enable), .start(start1),
        .in_sub_a(a1), .in_sub_b(b1), .out_sub_result(r1), .out_borrow(bo1),
        .busy(busy1), .done(done1)
`ifdef SERIAL_SUB_OVERFLOW_EN
        , .out_overflow(ovf1)
`endif
    );

    serial_subtractor #(.DATA_WIDTH(32), .DIGIT_WIDTH(32)) u2 (
        .clk(clk), .rst(rst), .enable(enable), .start(start2),
        .in_sub_a(a2), .in_sub_b(b2), .out_sub_result(r2), .out_borrow(bo2),
        .busy(busy2), .done(done2)
`ifdef SERIAL_SUB_OVERFLOW_EN
        , .out_overflow(ovf2)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sd;
        sd    = longint'($signed(a)) - longint'($signed(b));
        e.res = a - b;
        e.brw = a < b;
        e.ovf = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        return e;
    endfunction

    function automatic logic [31:0] rnd();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic dn(input int w);
        return w != 0 ? done2 : done1;
    endfunction

    function automatic logic bz(input int w);
        return w != 0 ? busy2 : busy1;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            mis++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        vec++;
        mis++;
        $display("FAIL %s: no done within cycle budget (cycle %0d)", nm, cyc);
    endtask

    always @(negedge clk) begin
        if (!done1) seen1 = 1'b0;
        else if (!seen1) begin
            seen1 = 1'b1;
            if (q1.size() == 0) timeout("unexpected_done1");
            else begin
                e1 = q1.pop_front();
                check("result_8", r1, e1.res);
                check("borrow_8", bo1, e1.brw);
`ifdef SERIAL_SUB_OVERFLOW_EN
                check("overflow_8", ovf1, e1.ovf);
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (!done2) seen2 = 1'b0;
        else if (!seen2) begin
            seen2 = 1'b1;
            if (q2.size() == 0) timeout("unexpected_done32");
            else begin
                e2 = q2.pop_front();
                check("result_32", r2, e2.res);
                check("borrow_32", bo2, e2.brw);
`ifdef SERIAL_SUB_OVERFLOW_EN
                check("overflow_32", ovf2, e2.ovf);
`endif
            end
        end
    end

    task automatic do_op(input int w, input logic [31:0] a, input logic [31:0] b,
                         input int stall_at, input int glitch_at, input bit hold_done);
        int k, nd, bcnt;
        bit got;
        nd = (w != 0) ? 1 : 4;
        @(posedge clk);
        #1;
        if (w != 0) begin
            a2 = a; b2 = b; start2 = 1'b1; q2.push_back(model(a, b));
        end else begin
            a1 = a; b1 = b; start1 = 1'b1; q1.push_back(model(a, b));
        end
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start2 = 1'b0;
        k = cyc;
        bcnt = 0;
        got = 1'b0;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            if (dn(w)) got = 1'b1;
            else begin
                bcnt += int'(bz(w));
                if (cyc - k == stall_at) begin
                    #1 enable = 1'b0;
                    repeat (3) @(posedge clk);
                    #1 enable = 1'b1;
                end
                if (cyc - k == glitch_at) begin
                    #1;
                    a1 = ~a; b1 = a; start1 = 1'b1;
                    @(posedge clk);
                    #1 start1 = 1'b0;
                end
            end
        end
        if (!got) timeout("op_done");
        else begin
            check("latency", cyc - k, nd + (stall_at >= 0 ? 3 : 0));
            if (stall_at < 0) check("busy_cycles", bcnt, nd);
            check("busy_at_done", bz(w), 1'b0);
            if (hold_done) begin
                #1 enable = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("done_stretch", dn(w), 1'b1);
                end
                #1 enable = 1'b1;
                @(negedge clk);
                check("done_clears", dn(w), 1'b0);
            end
        end
    endtask

    task automatic wait_done1(input int k, input string nm);
        bit got;
        got = 1'b0;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            got = done1;
        end
        if (!got) timeout(nm);
        else check(nm, cyc - k, 4);
    endtask

    initial begin
        int k;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_result", r1, 0);
        check("rst_borrow", bo1, 0);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_done32", done2, 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
        check("rst_ovf", ovf1, 0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;

        do_op(0, 32'd100, 32'd58, -1, -1, 1'b0);
        do_op(0, 32'd5, 32'd7, -1, -1, 1'b0);
        do_op(0, 32'h8000_0000, 32'd1, -1, -1, 1'b0);
        do_op(0, 32'd1, 32'd2, -1, -1, 1'b0);
        do_op(0, 32'h0000_1234, 32'h0000_0042, -1, 2, 1'b0);
        do_op(0, 32'hDEAD_BEEF, 32'h1234_5678, 1, -1, 1'b1);

        @(posedge clk);
        #1 a1 = 32'h0F0F_0F0F; b1 = 32'h1111_1111; start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrun_rst_result", r1, 0);
        check("midrun_rst_borrow", bo1, 0);
        check("midrun_rst_busy", busy1, 0);
        check("midrun_rst_done", done1, 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
        check("midrun_rst_ovf", ovf1, 0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        do_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, 1'b0);

        @(posedge clk);
        #1 a1 = 32'd1000; b1 = 32'd1; start1 = 1'b1; q1.push_back(model(32'd1000, 32'd1));
        @(posedge clk);
        #1 k = cyc;
        wait_done1(k, "b2b_latency_first");
        #1 a1 = 32'd7; b1 = 32'd9; q1.push_back(model(32'd7, 32'd9));
        @(posedge clk);
        #1 start1 = 1'b0;
        k = cyc;
        @(negedge clk);
        check("b2b_no_gap_busy", busy1, 1'b1);
        wait_done1(k, "b2b_latency_second");

        do_op(1, 32'd100, 32'd58, -1, -1, 1'b0);
        do_op(1, 32'd5, 32'd7, -1, -1, 1'b0);
        do_op(1, 32'h8000_0000, 32'd1, -1, -1, 1'b1);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            do_op(i % 2, rnd(), rnd(), -1, -1, 1'b0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", q1.size() + q2.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule
